ball_launcher: RTL
==================

Name: ball_launcher

Overview:
- Top-of-board ball source for the Turing Tumble fabric.
- Holds a blue and a red ball magazine and drops one ball per launch into the board.
  - Blue balls enter on o_left, which feeds the i_left input of the first cell.
  - Red balls enter on o_right, which feeds i_right.
- Consumes the bottom-of-board lever events: a lever hit releases the next ball of that lever's colour.
- Tracks one ball in flight. An interceptor catch or an empty magazine ends the run.

Parameters:
- BLUE_BALLS, 8, initial and refill count of the blue magazine (1..255).
- RED_BALLS, 8, initial and refill count of the red magazine (1..255).
- CNT_W, 8, width of the count outputs; must be at least $clog2(max(BLUE_BALLS,RED_BALLS)+1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- start_blue  input  1  user start, blue first ball; rising-edge event
- start_red  input  1  user start, red first ball; rising-edge event
- lever_left  input  1  ball reached left (blue) lever; rising-edge event
- lever_right  input  1  ball reached right (red) lever; rising-edge event
- intercept  input  1  ball caught by an interceptor; rising-edge event
- refill  input  1  reload both magazines; level, honoured only in IDLE
- o_left  output  1  blue ball drop pulse, 1 cycle
- o_right  output  1  red ball drop pulse, 1 cycle
- blue_cnt  output  CNT_W  blue balls remaining
- red_cnt  output  CNT_W  red balls remaining
- busy  output  1  ball in flight (FLIGHT state)
- starved  output  1  sticky: a requested colour was empty

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE; o_left, o_right, busy and starved go to 0.
  - blue_cnt goes to BLUE_BALLS and red_cnt to RED_BALLS.
  - Edge-detector history registers go to 0, so an input already high when rst releases counts as an edge on the first clock.
- All outputs are registered.
- Events are registered rising edges: the input is high this cycle and was low last cycle. An input held high produces exactly one event.
- States: IDLE, LAUNCH_B, LAUNCH_R, FLIGHT.
- IDLE:
  - start_blue event with blue_cnt>0 → LAUNCH_B.
  - start_red event with red_cnt>0 → LAUNCH_R.
  - Both events in the same cycle: blue wins.
  - Start event for an empty colour: stay in IDLE, set starved.
  - refill=1: counts reload to their parameters and starved clears. refill has priority over start in the same cycle; the start is dropped.
  - Lever and intercept events are ignored.
- LAUNCH_B / LAUNCH_R:
  - Lasts exactly 1 cycle. o_left (or o_right) is 1 for that cycle.
  - The matching count decrements at the end of that cycle.
  - Next state is FLIGHT unconditionally.
  - Latency: an event at edge N gives a pulse during cycle N+1, i.e. start input to pulse is 2 clocks.
- FLIGHT:
  - busy=1.
  - lever_left event: blue_cnt>0 → LAUNCH_B; otherwise → IDLE with starved set.
  - lever_right event: same behaviour on the red magazine, leading to LAUNCH_R.
  - Simultaneous lever events: left wins.
  - intercept event → IDLE, counts unchanged. intercept has priority over levers in the same cycle.
  - start and refill are ignored.
- Counts never wrap: a decrement only happens from a nonzero value.
- The o_left and o_right pulses are never both 1 in the same cycle.
- Reset mid-FLIGHT or mid-LAUNCH aborts the ball. Any pulse in progress drops immediately.

Decomposition:
- Package tt_pkg holds:
  - the launcher state enum (IDLE, LAUNCH_B, LAUNCH_R, FLIGHT);
  - a colour enum (BLUE, RED);
  - shared constants for the default magazine size.
- One sub-module, tt_edge_detect (parameterised width, clk/rst, registered rising-edge output), instantiated once over the 5 event inputs.

Test Plan:
- Reset, then start_blue held high for 5 cycles → exactly one o_left pulse, 2 clocks after the rising edge; blue_cnt 8→7; busy=1 afterwards.
- In FLIGHT, pulse lever_right → o_right pulse 2 clocks later, red_cnt 8→7. Then pulse lever_left → o_left pulse, blue_cnt 7→6.
- BLUE_BALLS=2: start_blue, then lever_left twice → two more launches are requested but only one succeeds. Result: blue_cnt=0, state IDLE, starved=1, and no third o_left pulse.
- In FLIGHT, intercept and lever_left rise in the same cycle → IDLE, no pulse, counts unchanged. Then refill=1 → counts reload to 8/8 and starved clears.
- start_blue and start_red rise together in IDLE → only o_left pulses. With both levers rising together in FLIGHT → only o_left pulses.
- Assert rst during the LAUNCH_R pulse cycle → o_right is 0 immediately and counts return to 8/8 without waiting for a clock edge.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and constants for the Turing Tumble ball launcher:
// launcher state, ball colour, default magazine size and event bit positions.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH_B = 2'd1,
    LAUNCH_R = 2'd2,
    FLIGHT   = 2'd3
  } launch_state_t;

  typedef enum logic {
    BLUE = 1'b0,
    RED  = 1'b1
  } colour_t;

  localparam int DEFAULT_BALLS = 8;
  localparam int DEFAULT_CNT_W = 8;

  // Bit positions of the rising-edge event vector.
  localparam int EV_START_BLUE = 0;
  localparam int EV_START_RED  = 1;
  localparam int EV_LEVER_L    = 2;
  localparam int EV_LEVER_R    = 3;
  localparam int EV_INTERCEPT  = 4;
  localparam int EV_W          = 5;

  function automatic launch_state_t launch_of(colour_t c);
    return (c == BLUE) ? LAUNCH_B : LAUNCH_R;
  endfunction

endpackage

// File: rtl/ball_launcher_if.sv
// Signal bundle between the board and the ball launcher, including the
// launcher state exposed for observation.
interface ball_launcher_if #(
  parameter int CNT_W = 8
);
  import tt_pkg::*;

  // Handshake: every input is a level sampled on clk with no ready/backpressure;
  // start/lever/intercept act on their rising edges, refill acts on its level.
  // o_left/o_right are single-cycle strobes with no acknowledge.
  logic             start_blue;
  logic             start_red;
  logic             lever_left;
  logic             lever_right;
  logic             intercept;
  logic             refill;
  logic             o_left;
  logic             o_right;
  logic [CNT_W-1:0] blue_cnt;
  logic [CNT_W-1:0] red_cnt;
  logic             busy;
  logic             starved;
  launch_state_t    state;

  modport master (
    output start_blue, start_red, lever_left, lever_right, intercept, refill,
    input  o_left, o_right, blue_cnt, red_cnt, busy, starved, state
  );

  modport slave (
    input  start_blue, start_red, lever_left, lever_right, intercept, refill,
    output o_left, o_right, blue_cnt, red_cnt, busy, starved, state
  );

endinterface

// File: rtl/tt_edge_detect.sv
// Registered rising-edge detector. History resets to 0, so an input already
// high when reset releases is reported as an edge on the first clock.
module tt_edge_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      rise <= '0;
    end else begin
      hist <= d;
      rise <= d & ~hist;
    end
  end

endmodule

// File: rtl/ball_launcher.sv
// Ball source at the top of the board: two magazines, one ball in flight,
// lever events request the next ball, interceptor catch or empty magazine stops.
module ball_launcher
  import tt_pkg::*;
#(
  parameter int BLUE_BALLS = DEFAULT_BALLS,
  parameter int RED_BALLS  = DEFAULT_BALLS,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input logic            clk,
  input logic            rst,
  ball_launcher_if.slave bus
);

  localparam logic [CNT_W-1:0] BLUE_INIT = CNT_W'(BLUE_BALLS);
  localparam logic [CNT_W-1:0] RED_INIT  = CNT_W'(RED_BALLS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [EV_W-1:0] ev_raw;
  logic [EV_W-1:0] ev;

  launch_state_t    state;
  launch_state_t    next_state;
  logic             starve_set;
  logic             req_valid;
  colour_t          req_col;
  logic             req_has_ball;

  logic [CNT_W-1:0] blue_cnt_q;
  logic [CNT_W-1:0] red_cnt_q;
  logic             starved_q;
  logic             o_left_q;
  logic             o_right_q;
  logic             busy_q;
  logic             o_left_d;
  logic             o_right_d;
  logic             busy_d;

  assign ev_raw[EV_START_BLUE] = bus.start_blue;
  assign ev_raw[EV_START_RED]  = bus.start_red;
  assign ev_raw[EV_LEVER_L]    = bus.lever_left;
  assign ev_raw[EV_LEVER_R]    = bus.lever_right;
  assign ev_raw[EV_INTERCEPT]  = bus.intercept;

  tt_edge_detect #(
    .W(EV_W)
  ) u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (ev_raw),
    .rise (ev)
  );

  // State register plus the registered Moore outputs derived from next_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      o_left_q  <= 1'b0;
      o_right_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= next_state;
      o_left_q  <= o_left_d;
      o_right_q <= o_right_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state: at most one colour is requested per cycle; blue/left wins ties.
  always_comb begin
    next_state   = state;
    starve_set   = 1'b0;
    req_valid    = 1'b0;
    req_col      = BLUE;
    req_has_ball = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.refill) begin
          req_valid = ev[EV_START_BLUE] | ev[EV_START_RED];
          req_col   = ev[EV_START_BLUE] ? BLUE : RED;
        end
      end
      LAUNCH_B, LAUNCH_R: begin
        next_state = FLIGHT;
      end
      FLIGHT: begin
        if (ev[EV_INTERCEPT]) begin
          next_state = IDLE;
        end else begin
          req_valid = ev[EV_LEVER_L] | ev[EV_LEVER_R];
          req_col   = ev[EV_LEVER_L] ? BLUE : RED;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    req_has_ball = (req_col == BLUE) ? (blue_cnt_q != '0) : (red_cnt_q != '0);
    if (req_valid) begin
      if (req_has_ball) begin
        next_state = launch_of(req_col);
      end else begin
        next_state = IDLE;
        starve_set = 1'b1;
      end
    end
  end

  always_comb begin
    o_left_d  = (next_state == LAUNCH_B);
    o_right_d = (next_state == LAUNCH_R);
    busy_d    = (next_state == FLIGHT);
  end

  // Magazines: reload only while idle; a decrement closes each launch cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blue_cnt_q <= BLUE_INIT;
      red_cnt_q  <= RED_INIT;
      starved_q  <= 1'b0;
    end else begin
      if ((state == IDLE) && bus.refill) begin
        blue_cnt_q <= BLUE_INIT;
        red_cnt_q  <= RED_INIT;
        starved_q  <= 1'b0;
      end else begin
        if (starve_set) begin
          starved_q <= 1'b1;
        end
        if ((state == LAUNCH_B) && (blue_cnt_q != '0)) begin
          blue_cnt_q <= blue_cnt_q - CNT_ONE;
        end
        if ((state == LAUNCH_R) && (red_cnt_q != '0)) begin
          red_cnt_q <= red_cnt_q - CNT_ONE;
        end
      end
    end
  end

  assign bus.o_left   = o_left_q;
  assign bus.o_right  = o_right_q;
  assign bus.busy     = busy_q;
  assign bus.starved  = starved_q;
  assign bus.blue_cnt = blue_cnt_q;
  assign bus.red_cnt  = red_cnt_q;
  assign bus.state    = state;

endmodule
